srl_arb: RTL and testbench
==========================

SRL_ARB -- requirements
Module: srl_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority with port 0 highest.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 has a shift operation pending.
REQ-005 SHALL have port req0_ready, output, 1 bit: requester 0 is accepted this cycle.
REQ-006 SHALL have port req0_a, input, 32 bits: requester 0 operand to shift.
REQ-007 SHALL have port req0_b, input, 32 bits: requester 0 shift amount; only bits [4:0] are used.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_a and req1_b, identical to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1 bit: result held and valid.
REQ-010 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port rsp_res, output, 32 bits: logical right shift result.
REQ-012 SHALL have port rsp_id, output, 1 bit: index of the requester that owns rsp_res.

Function
REQ-013 SHALL contain one shared combinational 32-bit logical right shifter; result = a >> b[4:0] with zero fill; b[31:5] ignored.
REQ-014 SHALL implement FSM with two states:
- IDLE: no result held.
- HOLD: result registered, rsp_valid=1.
REQ-015 In IDLE, SHALL assert reqN_ready combinationally for exactly one requester: the granted one among those with valid=1; both readys 0 when neither valid.
REQ-016 A transfer occurs when reqN_valid and reqN_ready are both 1; on that edge SHALL register the shifter output into rsp_res, N into rsp_id, and go to HOLD.
REQ-017 Latency SHALL be 1 cycle: accepted at edge k, rsp_valid=1 from the cycle after edge k.
REQ-018 In HOLD, SHALL keep both reqN_ready=0 and keep rsp_res and rsp_id stable until rsp_valid and rsp_ready are both 1.
REQ-019 On an rsp handshake, SHALL return to IDLE; the next accept is no earlier than the following cycle, so at most one operation is outstanding and peak throughput is one operation per 2 cycles.
REQ-020 With RR_EN=1, SHALL keep a 1-bit priority pointer (reset 0):
- both valid -> grant the port named by the pointer;
- after any grant -> pointer = ~(granted index).
REQ-021 With RR_EN=0, on contention SHALL always grant port 0; the pointer is unused.
REQ-022 With a single valid requester, SHALL grant it regardless of the pointer.
REQ-023 Requesters SHALL hold valid, a and b stable until accepted; a valid dropped before acceptance is a protocol violation with undefined result; the block requires no check for it.
REQ-024 SHALL allow rsp_ready to be high before rsp_valid, with no effect in IDLE.

Reset
REQ-025 On rst_n=0, asynchronously and at any time including HOLD, SHALL set:
- state = IDLE, rsp_valid = 0, rsp_res = 0, rsp_id = 0, pointer = 0;
- any held result is discarded.
REQ-026 While rst_n=0, SHALL drive req0_ready = req1_ready = 0.
REQ-027 Operation SHALL resume on the first rising clk edge after rst_n goes high.

Verification
REQ-028 Single op: req0 a=0x000000A5, b=2, rsp_ready=1 -> req0_ready=1 for 1 cycle; next cycle rsp_valid=1, rsp_res=0x00000029, rsp_id=0.
REQ-029 Ignore upper bits: req1 a=0x000000A5, b=0x00000021 -> rsp_res=0x00000052, rsp_id=1; also b=0 -> rsp_res=a; b=31 with a=0x80000000 -> rsp_res=1.
REQ-030 Contention, RR_EN=1, both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one rsp every 2 cycles.
REQ-031 Contention, RR_EN=0, both valid -> port 0 granted every time; port 1 granted only after req0_valid drops.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles after a result -> rsp_valid, rsp_res and rsp_id stable; both readys 0; after rsp_ready=1, handshake, then IDLE and the next grant.
REQ-033 Reset mid-operation: assert rst_n=0 in HOLD -> immediately rsp_valid=0, rsp_res=0, readys 0; after release, pointer=0 so port 0 wins first contention.

Source files
------------

// File: rtl/srl_arb.sv
// srl_arb: two requesters share one 32-bit logical right shifter.
// A granted request is registered and held until the consumer takes it;
// at most one operation is outstanding at any time.
module srl_arb #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_id
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ptr;
    logic        gnt_any;
    logic        gnt_id;
    logic        accept;
    logic [31:0] shift_a;
    logic [4:0]  shift_amt;
    logic [31:0] shift_res;

    // Only the low five bits of each shift amount matter.
    logic        unused_b_hi;
    assign unused_b_hi = ^{req0_b[31:5], req1_b[31:5]};

    assign rsp_valid = (state == HOLD);

    // Pick the requester: a lone requester always wins; on contention the
    // pointer decides in round-robin mode, port 0 otherwise.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = (RR_EN != 0) ? ptr : 1'b0;
        end else begin
            gnt_id = req1_valid;
        end
    end

    // Shared shifter, fed by the granted requester's operands.
    always_comb begin
        shift_a   = gnt_id ? req1_a : req0_a;
        shift_amt = gnt_id ? req1_b[4:0] : req0_b[4:0];
        shift_res = shift_a >> shift_amt;
    end

    // Next state and handshake outputs; readys are forced low during reset.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                    req0_ready = rst_n & ~gnt_id;
                    req1_ready = rst_n & gnt_id;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the result and its owner on acceptance; held through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res <= '0;
            rsp_id  <= 1'b0;
        end else if (accept) begin
            rsp_res <= shift_res;
            rsp_id  <= gnt_id;
        end
    end

    // Round-robin pointer: after a grant, the other port gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept && (RR_EN != 0)) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: tb/tb_srl_arb.sv
// tb_srl_arb: table-driven and hand-written sequences plus a randomized run
// against a transaction-level reference model for srl_arb.
module tb_srl_arb;

    logic        clk;
    logic        rst_n;

    // Round-robin instance signals.
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_res;

    // Fixed-priority instance signals.
    logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_id;
    logic [31:0] f_rsp_res;

    int n_tests;
    int n_fail;

    srl_arb #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id)
    );

    srl_arb #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_res(f_rsp_res), .rsp_id(f_rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req0_valid   = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready    = 1'b0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        f_req0_a = '0; f_req0_b = '0; f_req1_a = '0; f_req1_b = '0;
        f_rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Reference model state for the randomized run.
    bit          m_busy;
    bit          m_ptr;
    logic [31:0] m_res;
    bit          m_id;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{id: 1'b0, a: 32'h0000_00A5, b: 32'h0000_0002, exp: 32'h0000_0029};
        vecs[1] = '{id: 1'b1, a: 32'h0000_00A5, b: 32'h0000_0021, exp: 32'h0000_0052};
        vecs[2] = '{id: 1'b0, a: 32'h1234_5678, b: 32'h0000_0000, exp: 32'h1234_5678};
        vecs[3] = '{id: 1'b1, a: 32'h8000_0000, b: 32'h0000_001F, exp: 32'h0000_0001};
        vecs[4] = '{id: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFE4, exp: 32'h0FFF_FFFF};
        vecs[5] = '{id: 1'b1, a: 32'hDEAD_BEEF, b: 32'h0000_0010, exp: 32'h0000_DEAD};

        do_reset();
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_res", rsp_res, 32'd0);
        check("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
        check("reset_ready0", {31'b0, req0_ready}, 32'd0);
        check("reset_ready1", {31'b0, req1_ready}, 32'd0);
        check("reset_fp_rsp_valid", {31'b0, f_rsp_valid}, 32'd0);

        // Single-requester table: one op each, rsp_ready held high.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            if (vecs[i].id) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
            end
            @(negedge clk);
            check("tbl_ready0", {31'b0, req0_ready}, {31'b0, ~vecs[i].id});
            check("tbl_ready1", {31'b0, req1_ready}, {31'b0, vecs[i].id});
            check("tbl_idle_valid", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            check("tbl_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("tbl_rsp_res", rsp_res, vecs[i].exp);
            check("tbl_rsp_id", {31'b0, rsp_id}, {31'b0, vecs[i].id});
            check("tbl_hold_ready0", {31'b0, req0_ready}, 32'd0);
        end

        // Round-robin contention: grants alternate starting at port 0.
        do_reset();
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h0000_00F0; req0_b = 32'd4;
        req1_valid = 1'b1; req1_a = 32'h0000_F000; req1_b = 32'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ready0", {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", {31'b0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("rr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("rr_rsp_id", {31'b0, rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_rsp_res", rsp_res, (k % 2 == 1) ? 32'h0000_0F00 : 32'h0000_000F);
            check("rr_hold_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Fixed priority: port 0 always wins, port 1 only once port 0 drops.
        @(posedge clk); #1;
        f_rsp_ready  = 1'b1;
        f_req0_valid = 1'b1; f_req0_a = 32'h0000_0100; f_req0_b = 32'd8;
        f_req1_valid = 1'b1; f_req1_a = 32'h0000_0300; f_req1_b = 32'd8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fp_ready0", {31'b0, f_req0_ready}, 32'd1);
            check("fp_ready1", {31'b0, f_req1_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("fp_rsp_id", {31'b0, f_rsp_id}, 32'd0);
            check("fp_rsp_res", f_rsp_res, 32'd1);
            @(posedge clk);
        end
        #1;
        f_req0_valid = 1'b0;
        @(negedge clk);
        check("fp_ready1_alone", {31'b0, f_req1_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("fp_rsp_id1", {31'b0, f_rsp_id}, 32'd1);
        check("fp_rsp_res1", f_rsp_res, 32'd3);
        @(posedge clk); #1;
        f_req1_valid = 1'b0;

        // Backpressure: result held across 5 stalled cycles.
        do_reset();
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'h0000_1234; req1_b = 32'd4;
        @(negedge clk);
        check("bp_accept1", {31'b0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_0100; req0_b = 32'd8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rsp_res", rsp_res, 32'h0000_0123);
            check("bp_rsp_id", {31'b0, rsp_id}, 32'd1);
            check("bp_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'b0, rsp_valid}, 32'd1);
        check("bp_release_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_next_ready0", {31'b0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("bp_next_res", rsp_res, 32'd1);
        check("bp_next_id", {31'b0, rsp_id}, 32'd0);

        // Reset during HOLD: outputs clear at once, pointer back to 0.
        do_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'h0000_0080; req0_b = 32'd3;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'h0000_0040; req1_b = 32'd1;
        @(negedge clk);
        check("rst_hold_valid", {31'b0, rsp_valid}, 32'd1);
        check("rst_hold_res", rsp_res, 32'h0000_0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_async_res", rsp_res, 32'd0);
        check("rst_async_id", {31'b0, rsp_id}, 32'd0);
        check("rst_async_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        check("rst_held_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ptr_ready0", {31'b0, req0_ready}, 32'd1);
        check("rst_ptr_ready1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("rst_first_id", {31'b0, rsp_id}, 32'd0);
        check("rst_first_res", rsp_res, 32'h0000_0010);

        // Randomized run against a transaction-level model.
        do_reset();
        m_busy = 1'b0; m_ptr = 1'b0; m_res = '0; m_id = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit e_any, e_id;
            @(negedge clk);
            e_any = !m_busy && (req0_valid || req1_valid);
            if (req0_valid && req1_valid) e_id = m_ptr;
            else                          e_id = req1_valid;
            check("rnd_ready0", {31'b0, req0_ready}, {31'b0, e_any && !e_id});
            check("rnd_ready1", {31'b0, req1_ready}, {31'b0, e_any && e_id});
            check("rnd_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy});
            if (m_busy) begin
                check("rnd_rsp_res", rsp_res, m_res);
                check("rnd_rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
            end
            @(posedge clk);
            if (m_busy) begin
                if (rsp_ready) m_busy = 1'b0;
            end else if (e_any) begin
                m_busy = 1'b1;
                m_id   = e_id;
                m_res  = e_id ? (req1_a >> (req1_b % 32)) : (req0_a >> (req0_b % 32));
                m_ptr  = !e_id;
            end
            #1;
            if (!req0_valid || (e_any && !e_id)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid || (e_any && e_id)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = $urandom; req1_b = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
